tlc5920_rx: RTL
===============

Name: tlc5920_rx

Overview:
- Receiver for the serial LED-bar display bus: sclk/sin/latch/blank/csel, as driven by the tlc5920 transmitter.
- Oversamples the bus in the system clock domain and rebuilds the per-row shift words.
- Presents a full display frame in the same 4-row x 2-state x 16-column layout as the transmitter input.
- Used for loopback self-test of the display path and for bench monitoring; reports framing errors.

Parameters:
- g_rows, 4: number of display rows; row index is taken from csel_ib3.
- g_bits, 32: bits per row word (2 states x 16 columns), MSB first.
- g_timeout, 1023: system-clock cycles without an sclk rising edge before an in-progress row is abandoned.

Ports:
- clk  input  1  system clock, 100 MHz.
- rstn  input  1  asynchronous active-low reset.
- sclk_i  input  1  serial clock from the bus; asynchronous to clk.
- sin_i  input  1  serial data from the bus.
- latch_i  input  1  row latch strobe.
- blank_i  input  1  display blank.
- csel_ib3  input  3  row select.
- ledData_ob  output  g_rows*g_bits  last complete frame; row r occupies bits [r*g_bits +: g_bits].
- frame_valid_o  output  1  1-cycle pulse when ledData_ob updates.
- err_o  output  1  1-cycle pulse on any framing error.
- err_cnt_ob8  output  8  saturating framing-error count.

Behaviour:
- Synchronisation:
  - Every bus input passes through a 2-FF synchroniser.
  - sclk and latch rising edges are detected on the synchronised signals.
  - Bus timing requirement: sclk high and low times ≥3 clk cycles each.
- Shifting:
  - On each sclk rising edge, the synchronised sin is shifted in at the LSB; the first bit received ends up as the MSB.
  - bit_cnt increments and saturates at g_bits+1.
- State machine:
  - S_IDLE: bit_cnt=0. An sclk edge shifts one bit and moves to S_SHIFT.
  - S_SHIFT: shifting continues.
    - The sclk edge that would make bit_cnt exceed g_bits moves to S_OVERRUN and raises an error.
    - g_timeout cycles with no sclk edge: error, back to S_IDLE, bit_cnt cleared.
  - S_OVERRUN: further sclk edges are ignored. Only latch leaves this state (→ S_IDLE), and that latch raises no second error.
  - A latch edge in any state returns to S_IDLE and clears bit_cnt.
- Latch handling:
  - bit_cnt==g_bits and csel<g_rows: write the shift word into staging row csel and set row_mask[csel].
  - bit_cnt!=g_bits (including 0, in S_IDLE): error, nothing written.
  - csel≥g_rows: error, nothing written.
  - A latch edge coinciding with an sclk edge: the latch is processed first and the sclk edge is dropped.
- Frame assembly:
  - Rewriting a row before the frame completes overwrites the staged word without error.
  - When row_mask becomes all ones, staging is copied to ledData_ob and row_mask clears.
  - frame_valid_o pulses in the cycle after the completing latch edge is detected.
- Latency: bus latch edge to frame_valid_o is 4 clk cycles (2 synchroniser + 1 edge detect + 1 register).
- Errors: each error pulses err_o for one cycle and increments err_cnt_ob8, saturating at 255. Two errors can never occur in the same cycle.
- Reset: all outputs 0, state S_IDLE, row_mask 0, staging 0, synchronisers 0. A reset mid-row discards the partial word.

Optional Feature:
- Macro: TLC5920_RX_BLANK_EN.
- Defined:
  - A latch arriving while the synchronised blank_i=1 is accepted for bit-count checking but discarded: no row write, no mask update, no error.
  - A rising edge of blank_i clears row_mask.
- Undefined: blank_i passes only through the synchroniser and has no effect.

Test Plan:
- Shift 4 rows of 32 bits, csel 0..3, words 0x0000_0001/0x8000_0000/0xA5A5_5A5A/0xFFFF_0000 with sclk period 8 clk, latch after each row.
  - Required: one frame_valid_o pulse 4 clk after the 4th latch; ledData_ob = {0xFFFF_0000,0xA5A5_5A5A,0x8000_0000,0x0000_0001}; err_cnt_ob8=0.
- Send 31 bits then latch with csel=1.
  - Required: err_o pulse, err_cnt=1, row 1 not written, no frame_valid_o.
- Send 40 bits then latch.
  - Required: exactly one error, at the 33rd edge; latch accepted silently; state back to S_IDLE.
- Send 10 bits, then stall for 1100 cycles.
  - Required: timeout error at cycle 1023 after the last edge. A following clean 32-bit row latches without error.
- Latch with csel=5; then inject 300 framing errors.
  - Required: the csel=5 latch raises an error; err_cnt_ob8 saturates at 255.
- TLC5920_RX_BLANK_EN defined: complete rows 0..2, then latch row 3 with blank_i=1.
  - Required: no frame_valid_o and no error.
  - Then deassert blank and send rows 0..3 again. Required: frame_valid_o pulses once.

Source files
------------

// File: rtl/tlc5920_rx.sv
// Oversampling receiver for the tlc5920 LED-bar bus: rebuilds row words, assembles frames, flags framing errors.
// Optional feature macro TLC5920_RX_BLANK_EN: blank_i discards latches and clears the partially assembled frame.
module tlc5920_rx #(
  parameter int g_rows    = 4,
  parameter int g_bits    = 32,
  parameter int g_timeout = 1023
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     sclk_i,
  input  logic                     sin_i,
  input  logic                     latch_i,
  input  logic                     blank_i,
  input  logic [2:0]               csel_ib3,
  output logic [g_rows*g_bits-1:0] ledData_ob,
  output logic                     frame_valid_o,
  output logic                     err_o,
  output logic [7:0]               err_cnt_ob8
);
  localparam int CntW = $clog2(g_bits + 2);
  localparam int TmoW = $clog2(g_timeout + 1);
  localparam logic [CntW-1:0] BitsFull = CntW'(g_bits);
  localparam logic [CntW-1:0] BitsOvf  = CntW'(g_bits + 1);
  localparam logic [TmoW-1:0] TmoLast  = TmoW'(g_timeout - 1);
  localparam logic [3:0]      RowsLim  = 4'(g_rows);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_OVERRUN} state_t;

  // Synchroniser vector layout: {csel[2:0], blank, latch, sin, sclk}
  logic [6:0] bus_raw, sync1, sync2;
  logic [2:0] edge_q;
  logic       sclk_ev, latch_ev, sin_q, blank_q, blank_ev;
  logic [2:0] csel_q;

  assign bus_raw = {csel_ib3, blank_i, latch_i, sin_i, sclk_i};

  // NOTE: non-blocking assignments make every stage sample the previous cycle's value, forming a true pipeline.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1    <= '0;
      sync2    <= '0;
      edge_q   <= '0;
      sclk_ev  <= 1'b0;
      latch_ev <= 1'b0;
      blank_ev <= 1'b0;
      sin_q    <= 1'b0;
      blank_q  <= 1'b0;
      csel_q   <= '0;
    end else begin
      sync1    <= bus_raw;
      sync2    <= sync1;
      edge_q   <= {sync2[3], sync2[2], sync2[0]};
      sclk_ev  <= sync2[0] & ~edge_q[0];
      latch_ev <= sync2[2] & ~edge_q[1];
      blank_ev <= sync2[3] & ~edge_q[2];
      sin_q    <= sync2[1];
      blank_q  <= sync2[3];
      csel_q   <= sync2[6:4];
    end
  end

  logic blank_drop, blank_clr;
`ifdef TLC5920_RX_BLANK_EN
  assign blank_drop = blank_q;
  assign blank_clr  = blank_ev;
`else
  logic blank_unused;
  assign blank_unused = blank_q ^ blank_ev;
  assign blank_drop   = 1'b0;
  assign blank_clr    = 1'b0;
`endif

  state_t                   state_q, state_d;
  logic [g_bits-1:0]        shift_q;
  logic [CntW-1:0]          bit_cnt;
  logic [TmoW-1:0]          idle_cnt;
  logic [g_rows-1:0]        row_mask, mask_set;
  logic [g_rows*g_bits-1:0] staging, staging_nx;
  logic                     tmo_hit, do_shift, cnt_clr, row_wr, err_set, frame_done;

  assign tmo_hit = (state_q == S_SHIFT) && !sclk_ev && (idle_cnt == TmoLast);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // A latch edge wins over a coincident sclk edge.
  always_comb begin
    state_d = state_q;
    if (latch_ev) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (sclk_ev) state_d = S_SHIFT;
        S_SHIFT: begin
          if (sclk_ev && bit_cnt == BitsFull) state_d = S_OVERRUN;
          else if (tmo_hit)                   state_d = S_IDLE;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    do_shift = 1'b0;
    cnt_clr  = 1'b0;
    row_wr   = 1'b0;
    err_set  = 1'b0;
    if (latch_ev) begin
      cnt_clr = 1'b1;
      if (state_q != S_OVERRUN) begin
        if (bit_cnt != BitsFull)               err_set = 1'b1;
        else if (!blank_drop) begin
          if ({1'b0, csel_q} >= RowsLim)       err_set = 1'b1;
          else                                 row_wr  = 1'b1;
        end
      end
    end else if (sclk_ev && state_q != S_OVERRUN) begin
      do_shift = 1'b1;
      err_set  = (bit_cnt == BitsFull);
    end else if (tmo_hit) begin
      err_set = 1'b1;
      cnt_clr = 1'b1;
    end
  end

  always_comb begin
    staging_nx = staging;
    mask_set   = row_mask | (g_rows'(1) << csel_q);
    if (row_wr) staging_nx[int'(csel_q)*g_bits +: g_bits] = shift_q;
    frame_done = row_wr && (&mask_set);
  end

  // NOTE: the staging store is reset explicitly so a frame never exposes power-up garbage.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shift_q       <= '0;
      bit_cnt       <= '0;
      idle_cnt      <= '0;
      row_mask      <= '0;
      staging       <= '0;
      ledData_ob    <= '0;
      frame_valid_o <= 1'b0;
      err_o         <= 1'b0;
      err_cnt_ob8   <= '0;
    end else begin
      frame_valid_o <= frame_done;
      err_o         <= err_set;
      if (err_set && err_cnt_ob8 != 8'hFF) err_cnt_ob8 <= err_cnt_ob8 + 8'd1;

      if (cnt_clr) begin
        bit_cnt <= '0;
      end else if (do_shift) begin
        if (bit_cnt < BitsFull) begin
          shift_q <= {shift_q[g_bits-2:0], sin_q};
          bit_cnt <= bit_cnt + CntW'(1);
        end else begin
          bit_cnt <= BitsOvf;
        end
      end

      if (state_q != S_SHIFT || sclk_ev || latch_ev) idle_cnt <= '0;
      else                                           idle_cnt <= idle_cnt + TmoW'(1);

      staging <= staging_nx;
      if (frame_done) ledData_ob <= staging_nx;
      if (row_wr)     row_mask   <= frame_done ? '0 : mask_set;
      if (blank_clr)  row_mask   <= '0;
    end
  end
endmodule
